// File: rtl/fpcvt_seq_ctrl.sv
// Multi-cycle 12-bit two's-complement to 8-bit float (S, E[2:0], F[3:0]) converter, one shift per clock.
// Define FPCVT_FIXED_LAT_EN to pad NORM so every result appears a fixed 12 edges after accept.
module fpcvt_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             S,
    output logic [2:0]       E,
    output logic [3:0]       F,
    output logic [CNT_W-1:0] conv_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [11:0] d_reg;
    logic [11:0] mag_reg;
    logic [3:0]  cnt_reg;
    logic        norm_stop;
    logic        norm_exit;
    logic [2:0]  e_rnd;
    logic [3:0]  f_rnd;

    assign norm_stop = mag_reg[11] | (cnt_reg == 4'd8);

`ifdef FPCVT_FIXED_LAT_EN
    // Counts NORM cycles independently of shifting; NORM is left after its tenth cycle.
    logic [3:0] pad_reg;
    assign norm_exit = (pad_reg == 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_reg <= 4'd0;
        end else if (state_reg == ABS) begin
            pad_reg <= 4'd0;
        end else if (state_reg == NORM) begin
            pad_reg <= pad_reg + 4'd1;
        end
    end
`else
    assign norm_exit = norm_stop;
`endif

    assign in_ready = (state_reg == IDLE) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = ABS;
            ABS:     state_next = NORM;
            NORM:    if (norm_exit) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Rounding from the normalised magnitude; a 5-bit F sum exposes the carry-out.
    logic [4:0] f_sum;
    logic [3:0] e_wide;
    always_comb begin
        f_sum  = {1'b0, mag_reg[11:8]} + {4'd0, mag_reg[7]};
        e_wide = 4'd8 - cnt_reg;
        f_rnd  = f_sum[3:0];
        if (cnt_reg == 4'd8) begin
            e_wide = 4'd0;
            f_rnd  = mag_reg[11:8];
        end else if (f_sum[4]) begin
            e_wide = e_wide + 4'd1;
            f_rnd  = 4'b1000;
        end
        if (e_wide > 4'd7) begin
            e_rnd = 3'd7;
            f_rnd = 4'b1111;
        end else begin
            e_rnd = e_wide[2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg      <= 12'd0;
            mag_reg    <= 12'd0;
            cnt_reg    <= 4'd0;
            S          <= 1'b0;
            E          <= 3'd0;
            F          <= 4'd0;
            out_valid  <= 1'b0;
            conv_count <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        d_reg <= D;
                        S     <= D[11];
                    end
                end
                ABS: begin
                    // -2048 has no positive 12-bit counterpart, so it clamps to 2047.
                    if (d_reg == 12'h800) begin
                        mag_reg <= 12'h7FF;
                    end else if (d_reg[11]) begin
                        mag_reg <= 12'd0 - d_reg;
                    end else begin
                        mag_reg <= d_reg;
                    end
                    cnt_reg <= 4'd0;
                end
                NORM: begin
                    if (!norm_stop) begin
                        mag_reg <= {mag_reg[10:0], 1'b0};
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                ROUND: begin
                    E         <= e_rnd;
                    F         <= f_rnd;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        conv_count <= conv_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpcvt_seq_ctrl.sv
// Directed bench for fpcvt_seq_ctrl: hand-computed conversions, latency, back-pressure, reset and count wrap.
// A 3-bit counter is used so the wrap is reached within a handful of conversions.
module tb_fpcvt_seq_ctrl;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [11:0]   D;
    logic          out_valid;
    logic          out_ready;
    logic          S;
    logic [2:0]    E;
    logic [3:0]    F;
    logic [CW-1:0] conv_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    fpcvt_seq_ctrl #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .D          (D),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .S          (S),
        .E          (E),
        .F          (F),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int lat_of(input int n);
`ifdef FPCVT_FIXED_LAT_EN
        lat_of = 12 + 0 * n;
`else
        lat_of = 3 + n;
`endif
    endfunction

    // Accept d, wait for out_valid, check result and latency; optionally hold off, then hand off.
    task automatic convert(input string tag, input logic [11:0] d, input int es, input int ee,
                           input int ef, input int n, input bit pre_ready, input int hold);
        int lat;
        lat = 0;
        check({tag, "_in_ready"}, int'(in_ready), 1);
        D         = d;
        in_valid  = 1'b1;
        out_ready = pre_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        D        = 12'hA5A;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, lat_of(n));
        check({tag, "_S"}, int'(S), es);
        check({tag, "_E"}, int'(E), ee);
        check({tag, "_F"}, int'(F), ef);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            D        = 12'h7FF;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, int'(out_valid), 1);
            check({tag, "_hold_ready"}, int'(in_ready), 0);
            check({tag, "_hold_SEF"}, int'({S, E, F}), (es << 7) | (ee << 4) | ef);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt   = (exp_cnt + 1) % (1 << CW);
        $display("conv %s D=%03h -> S=%0d E=%0d F=%04b lat=%0d count=%0d", tag, d, S, E, F, lat, conv_count);
        check({tag, "_count"}, int'(conv_count), exp_cnt);
        check({tag, "_ov_low"}, int'(out_valid), 0);
        check({tag, "_in_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        D         = 12'h000;
        @(posedge clk); #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out", int'({out_valid, S, E, F, conv_count}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Abandon a conversion mid-NORM.
        D        = 12'h00D;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out", int'({out_valid, S, E, F, conv_count}), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        $display("reset mid-NORM done");

        convert("n3",    12'h170, 0, 5, 4'b1100, 3, 1'b0, 0);
        convert("zero",  12'h000, 0, 0, 4'b0000, 8, 1'b0, 0);
        convert("d00d",  12'h00D, 0, 0, 4'b1101, 8, 1'b0, 0);
        convert("neg",   12'h800, 1, 7, 4'b1111, 1, 1'b0, 0);
        convert("pmax",  12'h7FF, 0, 7, 4'b1111, 1, 1'b1, 0);
        convert("carry", 12'h0F8, 0, 5, 4'b1000, 4, 1'b0, 0);
        convert("m1",    12'hFFF, 1, 0, 4'b0001, 8, 1'b1, 0);
        convert("hold",  12'h123, 0, 5, 4'b1001, 3, 1'b0, 5);
        convert("wrap",  12'h170, 0, 5, 4'b1100, 3, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
